// File: rtl/cpu_pkg.sv
// Shared opcode constants, instruction field positions and sequencer state codes
// for the control unit, register bank and ALU.
package cpu_pkg;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLR     = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    localparam int OPCODE_MSB = 17;
    localparam int OPCODE_LSB = 15;
    localparam int DEST_MSB   = 14;
    localparam int DEST_LSB   = 11;
    localparam int ADDR1_MSB  = 10;
    localparam int ADDR1_LSB  = 7;
    localparam int ADDR2_MSB  = 6;
    localparam int ADDR2_LSB  = 3;
    localparam int SIGN_BIT   = 6;
    localparam int IMM_MSB    = 5;
    localparam int IMM_LSB    = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic is_imm(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

endpackage

// File: rtl/instr_fields.sv
// Combinational split of an instruction word into the bank-facing fields,
// zeroing whichever operand fields do not apply to the instruction's form.
module instr_fields
    import cpu_pkg::*;
(
    input  logic [17:0] instr,
    output logic [2:0]  opcode,
    output logic [3:0]  dest,
    output logic [3:0]  addr1,
    output logic [3:0]  addr2,
    output logic        sinalImm,
    output logic [5:0]  Imm
);

    logic imm_form;

    // Bits [6:0] are either a second register address or a signed immediate.
    always_comb begin
        opcode   = instr[OPCODE_MSB:OPCODE_LSB];
        dest     = instr[DEST_MSB:DEST_LSB];
        addr1    = instr[ADDR1_MSB:ADDR1_LSB];
        imm_form = is_imm(instr[OPCODE_MSB:OPCODE_LSB]);
        addr2    = 4'd0;
        sinalImm = 1'b0;
        Imm      = 6'd0;
        if (imm_form) begin
            sinalImm = instr[SIGN_BIT];
            Imm      = instr[IMM_MSB:IMM_LSB];
        end else begin
            addr2    = instr[ADDR2_MSB:ADDR2_LSB];
        end
    end

endmodule

// File: rtl/control_unit.sv
// Single-issue instruction sequencer: IDLE -> READ -> WRITE (or show) -> DONE.
// Optional retirement counter enabled by defining CONTROL_UNIT_RETIRE_CNT_EN.
module control_unit
    import cpu_pkg::*;
#(
    parameter int INSTR_W     = 18,
    parameter int WB_CYCLES   = 1,
    parameter int READ_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [2:0]         opcode,
    output logic [3:0]         dest,
    output logic [3:0]         addr1,
    output logic [3:0]         addr2,
    output logic               sinalImm,
    output logic [5:0]         Imm,
    output logic               we,
    output logic               show,
    output logic               done
`ifdef CONTROL_UNIT_RETIRE_CNT_EN
    ,
    output logic [15:0]        retired
`endif
);

    localparam logic [2:0] READ_LOAD = 3'(READ_CYCLES - 1);
    localparam logic [2:0] WB_LOAD   = 3'(WB_CYCLES - 1);

    logic [1:0] state;
    logic [2:0] phase;

    logic [2:0] next_opcode;
    logic [3:0] next_dest;
    logic [3:0] next_addr1;
    logic [3:0] next_addr2;
    logic       next_sinal;
    logic [5:0] next_imm;

    instr_fields u_fields (
        .instr    (instr),
        .opcode   (next_opcode),
        .dest     (next_dest),
        .addr1    (next_addr1),
        .addr2    (next_addr2),
        .sinalImm (next_sinal),
        .Imm      (next_imm)
    );

    // Fields are only loaded on a handshake, so they are settled a full cycle before we rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            phase    <= 3'd0;
            opcode   <= 3'd0;
            dest     <= 4'd0;
            addr1    <= 4'd0;
            addr2    <= 4'd0;
            sinalImm <= 1'b0;
            Imm      <= 6'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        opcode   <= next_opcode;
                        dest     <= next_dest;
                        addr1    <= next_addr1;
                        addr2    <= next_addr2;
                        sinalImm <= next_sinal;
                        Imm      <= next_imm;
                        phase    <= READ_LOAD;
                        state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (phase == 3'd0) begin
                        phase <= WB_LOAD;
                        state <= (opcode == OP_DISPLAY) ? ST_DONE : ST_WRITE;
                    end else begin
                        phase <= phase - 3'd1;
                    end
                end
                ST_WRITE: begin
                    if (phase == 3'd0) begin
                        state <= ST_DONE;
                    end else begin
                        phase <= phase - 3'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // DISPLAY skips the write phase and pulses show in its final read cycle instead.
    always_comb begin
        instr_ready = (state == ST_IDLE) && !rst;
        we          = (state == ST_WRITE);
        show        = (state == ST_READ) && (phase == 3'd0) && (opcode == OP_DISPLAY);
        done        = (state == ST_DONE);
    end

`ifdef CONTROL_UNIT_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= 16'd0;
        end else if (state == ST_DONE) begin
            retired <= retired + 16'd1;
        end
    end
`endif

endmodule
